// File: rtl/serial_subtractor_with_overflow_if.sv
// Start/done handshake and result bus for the bit-serial subtractor.
// Use the master modport on the ALU sequencer side and the slave modport on
// the subtractor side.
//   start      : request; a/b are sampled on that edge if the block is free
//   a, b       : minuend, subtrahend
//   busy       : a subtraction is in progress
//   done       : one-cycle pulse; results are valid from this cycle
//   diff       : registered difference, zeroed (or saturated) on overflow
//   borrow_out : unsigned borrow, set when a < b unsigned
//   overflow   : signed overflow flag
interface serial_subtractor_with_overflow_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor_with_overflow.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit
// per clock. A result appears WIDTH+1 cycles after start is accepted.
// By default diff is forced to zero on signed overflow. When
// SUB_SATURATE_EN is defined, diff instead saturates to the most positive
// or most negative value, chosen by the sign of a.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_subtractor_with_overflow_if
//           (start/a/b in; busy/done/diff/borrow_out/overflow out)
module serial_subtractor_with_overflow #(
  parameter int unsigned WIDTH = 8
) (
  input logic                                    clk,
  input logic                                    rst_n,
  serial_subtractor_with_overflow_if.slave       bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               overflow_q, overflow_d;

  logic               a_i, b_i, d_i, borrow_nx, last_bit, ovf_nx;
  logic [WIDTH-1:0]   raw_diff;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state logic; DONE accepts a new start for back-to-back operation
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit)  state_d = ST_DONE;
      ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // One full-subtractor bit per cycle
  assign a_i       = a_sh_q[0];
  assign b_i       = b_sh_q[0];
  assign d_i       = a_i ^ b_i ^ borrow_q;
  assign borrow_nx = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_q);
  assign raw_diff  = {d_i, res_q[WIDTH-1:1]};
  // On the last bit the operand LSBs are the original sign bits
  assign ovf_nx    = (a_i != b_i) & (d_i != a_i);

  always_comb begin
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_SHIFT: begin
        res_d    = raw_diff;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          borrow_out_d = borrow_nx;
          overflow_d   = ovf_nx;
          if (ovf_nx) begin
`ifdef SUB_SATURATE_EN
            diff_d = a_i ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
            diff_d = '0;
`endif
          end else begin
            diff_d = raw_diff;
          end
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy       = (state_q == ST_SHIFT);
    bus.done       = (state_q == ST_DONE);
    bus.diff       = diff_q;
    bus.borrow_out = borrow_out_q;
    bus.overflow   = overflow_q;
  end
endmodule

// File: tb/tb_serial_subtractor_with_overflow.sv
// Directed-vector bench for serial_subtractor_with_overflow (WIDTH=8).
module tb_serial_subtractor_with_overflow;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtractor_with_overflow_if #(.WIDTH(8)) bus ();

  serial_subtractor_with_overflow #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SUB_SATURATE_EN
  localparam logic [7:0] OVF_NEG_DIFF = 8'h80;
  localparam logic [7:0] OVF_POS_DIFF = 8'h7F;
`else
  localparam logic [7:0] OVF_NEG_DIFF = 8'h00;
  localparam logic [7:0] OVF_POS_DIFF = 8'h00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge; returns at the first negedge after sampling
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
  endtask

  // Walks negedges until done or a bounded budget; lat counts cycles since
  // the sampling edge, so done should show up at lat == 9
  task automatic wait_done(input int lat0, output int lat, output int busy_cyc);
    lat      = lat0;
    busy_cyc = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] ed,
                              input logic eb, input logic eo);
    check({tag, "_diff"},   32'(bus.diff),       32'(ed));
    check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(eb));
    check({tag, "_ovf"},    32'(bus.overflow),   32'(eo));
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check_result("rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 5 - 3
    start_op(8'h05, 8'h03);
    wait_done(1, lat, bc);
    check("t1_latency", 32'(lat), 9);
    check("t1_busy_cycles", 32'(bc), 8);
    check("t1_busy_in_done", 32'(bus.busy), 0);
    check_result("t1", 8'h02, 1'b0, 1'b0);

    // 3 - 5; previous results must hold while shifting
    start_op(8'h03, 8'h05);
    check("t2_hold_diff", 32'(bus.diff), 32'h02);
    wait_done(1, lat, bc);
    check("t2_latency", 32'(lat), 9);
    check_result("t2", 8'hFE, 1'b1, 1'b0);

    // -128 - 1: negative overflow
    start_op(8'h80, 8'h01);
    wait_done(1, lat, bc);
    check_result("t3", OVF_NEG_DIFF, 1'b0, 1'b1);

    // start while busy is ignored, then back-to-back from DONE
    start_op(8'h10, 8'h01);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, lat, bc);
    check("t5_latency", 32'(lat), 9);
    check_result("t5", 8'h0F, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.a     = 8'h20;
    bus.b     = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    check("t5b_busy", 32'(bus.busy), 1);
    wait_done(1, lat, bc);
    check("t5b_latency", 32'(lat), 9);
    check_result("t5b", 8'h00, 1'b0, 1'b0);

    // 127 - (-1): positive overflow
    start_op(8'h7F, 8'hFF);
    wait_done(1, lat, bc);
    check_result("t4", OVF_POS_DIFF, 1'b1, 1'b1);

    // Asynchronous reset mid-operation
    start_op(8'h33, 8'h11);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_done", 32'(bus.done), 0);
    check_result("t6", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("t6_no_done", 32'(done_seen), 0);
    start_op(8'h00, 8'h01);
    wait_done(1, lat, bc);
    check("t7_latency", 32'(lat), 9);
    check_result("t7", 8'hFF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
